fmt_unpack_pipe: RTL and testbench

//  Multi-lane, pipelined successor to the per-format bias/fraction-width lookup.
//  Per lane: checks NaN-boxing; unpacks sign, exponent and significand into max-format fields.

---
 rtl/fmt_unpack_pipe.sv | 206 ++++++++++++++++++++
 tb/tb_fmt_unpack_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fmt_unpack_pipe.sv
// Multi-lane pipelined FP operand unpacker: NaN-box check, field unpack, per-format Bias/Nf.
// Optional FMT_UNPACK_CLASS_EN adds a per-lane Class output {nan, inf, subnorm, zero, snan}.
module fmt_unpack_pipe #(
  parameter int unsigned FLEN          = 64,
  parameter int unsigned NE            = 11,
  parameter int unsigned NF            = 52,
  parameter int unsigned LOGFLEN       = 7,
  parameter int unsigned LANES         = 3,
  parameter int unsigned STAGES        = 1,
  parameter int unsigned ZFH_SUPPORTED = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     InValid,
  output logic                     InReady,
  input  logic [1:0]               Fmt,
  input  logic [LANES*FLEN-1:0]    X,
  output logic                     OutValid,
  input  logic                     OutReady,
  output logic [LANES-1:0]         Sgn,
  output logic [LANES*NE-1:0]      Exp,
  output logic [LANES*(NF+1)-1:0]  Sig,
  output logic [NE-2:0]            Bias,
  output logic [LOGFLEN-1:0]       Nf,
  output logic                     FmtIllegal
`ifdef FMT_UNPACK_CLASS_EN
  ,
  output logic [LANES*5-1:0]       Class
`endif
);

  localparam int unsigned BW = NE - 1;
`ifdef FMT_UNPACK_CLASS_EN
  localparam int unsigned DW = LANES + LANES*NE + LANES*(NF+1) + BW + LOGFLEN + 1 + LANES*5;
`else
  localparam int unsigned DW = LANES + LANES*NE + LANES*(NF+1) + BW + LOGFLEN + 1;
`endif

  typedef struct packed {
    logic          sgn;
    logic [NE-1:0] exp;
    logic [NF:0]   sig;
`ifdef FMT_UNPACK_CLASS_EN
    logic [4:0]    cls;
`endif
  } lane_t;

  // Fields are first extracted into max-width (quad) containers with the fraction
  // left-justified, then narrowed to the configured NE/NF widths.
  function automatic lane_t unpack_lane(input logic [127:0] xw, input logic [1:0] fmt);
    lane_t        r;
    int unsigned  w;
    logic         sign;
    logic [14:0]  e;
    logic [14:0]  emax;
    logic [14:0]  e_out;
    logic [111:0] f;
    logic [112:0] sig_w;
    logic [127:0] hi;
    r    = '0;
    w    = 32;
    sign = xw[31];
    emax = 15'h00ff;
    e    = 15'(xw[30:23]);
    f    = {xw[22:0], 89'b0};
    case (fmt)
      2'd0: ;
      2'd1: begin
        w = 64; sign = xw[63]; emax = 15'h07ff; e = 15'(xw[62:52]); f = {xw[51:0], 60'b0};
      end
      2'd2: begin
        w = 16; sign = xw[15]; emax = 15'h001f; e = 15'(xw[14:10]); f = {xw[9:0], 102'b0};
      end
      2'd3: begin
        w = 128; sign = xw[127]; emax = 15'h7fff; e = xw[126:112]; f = xw[111:0];
      end
    endcase
    // Bits [FLEN-1:w] must be ones; empty when the format fills the register.
    hi = ((128'd1 << FLEN) - 128'd1) & ~((128'd1 << w) - 128'd1);
    if ((xw & hi) != hi) begin
      e_out = emax;
      sig_w = {2'b11, 111'b0};
`ifdef FMT_UNPACK_CLASS_EN
      r.cls = 5'b10000;
`endif
    end else begin
      r.sgn = sign;
      e_out = (e == '0 && f != '0) ? 15'd1 : e;
      sig_w = {e != '0, f};
`ifdef FMT_UNPACK_CLASS_EN
      r.cls[4] = (e == emax) && (f != '0);
      r.cls[3] = (e == emax) && (f == '0);
      r.cls[2] = (e == '0) && (f != '0);
      r.cls[1] = (e == '0) && (f == '0);
      r.cls[0] = (e == emax) && (f != '0) && !f[111];
`endif
    end
    r.exp = NE'(e_out);
    r.sig = (NF+1)'(sig_w >> (112 - NF));
    return r;
  endfunction

  logic                    fmt_legal;
  logic [BW-1:0]           bias_c;
  logic [LOGFLEN-1:0]      nf_c;
  logic [LANES-1:0]        in_sgn;
  logic [LANES*NE-1:0]     in_exp;
  logic [LANES*(NF+1)-1:0] in_sig;
`ifdef FMT_UNPACK_CLASS_EN
  logic [LANES*5-1:0]      in_cls;
`endif
  logic [DW-1:0]           in_data;

  always_comb begin
    fmt_legal = 1'b0;
    bias_c    = '0;
    nf_c      = '0;
    case (Fmt)
      2'd0: begin fmt_legal = (FLEN >= 32);        bias_c = BW'(127);   nf_c = LOGFLEN'(23);  end
      2'd1: begin fmt_legal = (FLEN >= 64);        bias_c = BW'(1023);  nf_c = LOGFLEN'(52);  end
      2'd2: begin fmt_legal = (ZFH_SUPPORTED != 0); bias_c = BW'(15);   nf_c = LOGFLEN'(10);  end
      2'd3: begin fmt_legal = (FLEN == 128);       bias_c = BW'(16383); nf_c = LOGFLEN'(112); end
    endcase
    if (!fmt_legal) begin
      bias_c = '0;
      nf_c   = '0;
    end
  end

  always_comb begin
    lane_t r;
    r      = '0;
    in_sgn = '0;
    in_exp = '0;
    in_sig = '0;
`ifdef FMT_UNPACK_CLASS_EN
    in_cls = '0;
`endif
    for (int l = 0; l < LANES; l++) begin
      r = unpack_lane(128'(X[l*FLEN +: FLEN]), Fmt);
      if (fmt_legal) begin
        in_sgn[l]                 = r.sgn;
        in_exp[l*NE +: NE]        = r.exp;
        in_sig[l*(NF+1) +: NF+1]  = r.sig;
`ifdef FMT_UNPACK_CLASS_EN
        in_cls[l*5 +: 5]          = r.cls;
`endif
      end
    end
  end

`ifdef FMT_UNPACK_CLASS_EN
  assign in_data = {in_cls, ~fmt_legal, nf_c, bias_c, in_sig, in_exp, in_sgn};
`else
  assign in_data = {~fmt_legal, nf_c, bias_c, in_sig, in_exp, in_sgn};
`endif

  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] stage_v_in;
  logic [DW-1:0]     data_q     [STAGES];
  logic [DW-1:0]     stage_d_in [STAGES];

  // Ready ripples back from the output so bubbles in any stage are filled.
  always_comb begin
    logic adv;
    adv  = OutReady;
    load = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k] = ~valid_q[k] | adv;
      adv     = load[k];
    end
  end

  always_comb begin
    stage_v_in[0] = InValid;
    stage_d_in[0] = in_data;
    for (int k = 1; k < STAGES; k++) begin
      stage_v_in[k] = valid_q[k-1];
      stage_d_in[k] = data_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) data_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          valid_q[k] <= stage_v_in[k];
          if (stage_v_in[k]) data_q[k] <= stage_d_in[k];
        end
      end
    end
  end

  assign InReady  = load[0];
  assign OutValid = valid_q[STAGES-1];
`ifdef FMT_UNPACK_CLASS_EN
  assign {Class, FmtIllegal, Nf, Bias, Sig, Exp, Sgn} = data_q[STAGES-1];
`else
  assign {FmtIllegal, Nf, Bias, Sig, Exp, Sgn} = data_q[STAGES-1];
`endif

endmodule

// File: tb/tb_fmt_unpack_pipe.sv
// Directed bench for fmt_unpack_pipe: single-stage unpack vectors plus a two-stage flow/reset test.
module tb_fmt_unpack_pipe;
  localparam int FLEN  = 64;
  localparam int NE    = 11;
  localparam int NF    = 52;
  localparam int LANES = 3;

  localparam logic [52:0] ONE = 53'h10000000000000;
  localparam logic [52:0] QN  = 53'h18000000000000;

  logic clk = 1'b0;
  logic reset;

  logic                     in_valid, in_ready, out_valid, out_ready, fmt_illegal;
  logic [1:0]               fmt;
  logic [LANES*FLEN-1:0]    x;
  logic [LANES-1:0]         sgn;
  logic [LANES*NE-1:0]      exp1;
  logic [LANES*(NF+1)-1:0]  sig;
  logic [NE-2:0]            bias;
  logic [6:0]               nf;

  logic                     in_valid2, in_ready2, out_valid2, out_ready2, fmt_illegal2;
  logic [1:0]               fmt2;
  logic [LANES*FLEN-1:0]    x2;
  logic [LANES-1:0]         sgn2;
  logic [LANES*NE-1:0]      exp2;
  logic [LANES*(NF+1)-1:0]  sig2;
  logic [NE-2:0]            bias2;
  logic [6:0]               nf2;
`ifdef FMT_UNPACK_CLASS_EN
  logic [LANES*5-1:0]       cls, cls2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  fmt_unpack_pipe #(.STAGES(1)) dut (
    .clk(clk), .reset(reset), .InValid(in_valid), .InReady(in_ready), .Fmt(fmt), .X(x),
    .OutValid(out_valid), .OutReady(out_ready), .Sgn(sgn), .Exp(exp1), .Sig(sig),
    .Bias(bias), .Nf(nf), .FmtIllegal(fmt_illegal)
`ifdef FMT_UNPACK_CLASS_EN
    , .Class(cls)
`endif
  );

  fmt_unpack_pipe #(.STAGES(2)) dut2 (
    .clk(clk), .reset(reset), .InValid(in_valid2), .InReady(in_ready2), .Fmt(fmt2), .X(x2),
    .OutValid(out_valid2), .OutReady(out_ready2), .Sgn(sgn2), .Exp(exp2), .Sig(sig2),
    .Bias(bias2), .Nf(nf2), .FmtIllegal(fmt_illegal2)
`ifdef FMT_UNPACK_CLASS_EN
    , .Class(cls2)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // One request into the single-stage DUT; returns at the negedge its result is visible.
  task automatic req1(input logic [1:0] f, input logic [LANES*FLEN-1:0] xv);
    @(negedge clk);
    in_valid = 1'b1;
    fmt      = f;
    x        = xv;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    int sent, recv, occ;
    logic stall_prev;
    logic [LANES*(NF+1)-1:0] sig_prev;

    reset = 1'b1;
    in_valid = 1'b0; fmt = '0; x = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; fmt2 = '0; x2 = '0; out_ready2 = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_outvalid", out_valid, 1'b0);
    check("rst_inready", in_ready, 1'b1);
    check("rst_sig", sig, '0);
    check("rst_exp", exp1, '0);
    check("rst_outvalid2", out_valid2, 1'b0);
    check("rst_inready2", in_ready2, 1'b1);
    reset = 1'b0;

    // Single: boxed 1.0, boxed -2.0, boxed subnormal
    req1(2'd0, {64'hFFFFFFFF_00000001, 64'hFFFFFFFF_C0000000, 64'hFFFFFFFF_3F800000});
    check("s_valid", out_valid, 1'b1);
    check("s_sgn", sgn, 3'b010);
    check("s_exp", exp1, {11'd1, 11'd128, 11'd127});
    check("s_sig", sig, {53'h20000000, ONE, ONE});
    check("s_bias", bias, 10'd127);
    check("s_nf", nf, 7'd23);
    check("s_illegal", fmt_illegal, 1'b0);

    // Single: unboxed, +inf, badly boxed
    req1(2'd0, {64'hFFFFFFFE_FFFFFFFF, 64'hFFFFFFFF_7F800000, 64'h00000000_3F800000});
    check("s_nanbox_sgn", sgn, 3'b000);
    check("s_nanbox_exp", exp1, {11'd255, 11'd255, 11'd255});
    check("s_nanbox_sig", sig, {QN, ONE, QN});
`ifdef FMT_UNPACK_CLASS_EN
    check("s_nanbox_cls", cls, {5'b10000, 5'b01000, 5'b10000});
`endif

    // Double: subnormal 1, 1.0, -0
    req1(2'd1, {64'h8000000000000000, 64'h3FF0000000000000, 64'h0000000000000001});
    check("d_sgn", sgn, 3'b100);
    check("d_exp", exp1, {11'd0, 11'd1023, 11'd1});
    check("d_sig", sig, {53'd0, ONE, 53'd1});
    check("d_bias", bias, 10'd1023);
    check("d_nf", nf, 7'd52);

    // Half: 1.0, boxed signalling NaN, unboxed
    req1(2'd2, {64'h0000000000003C00, 64'hFFFFFFFFFFFFFC01, 64'hFFFFFFFFFFFF3C00});
    check("h_sgn", sgn, 3'b010);
    check("h_exp", exp1, {11'd31, 11'd31, 11'd15});
    check("h_sig", sig, {QN, 53'h10040000000000, ONE});
    check("h_bias", bias, 10'd15);
    check("h_nf", nf, 7'd10);
`ifdef FMT_UNPACK_CLASS_EN
    check("h_cls", cls, {5'b10000, 5'b10001, 5'b00000});
`endif

    // Quad is illegal at FLEN=64
    req1(2'd3, {64'h3FF0000000000000, 64'hFFFFFFFF_3F800000, 64'h0000000000000001});
    check("q_valid", out_valid, 1'b1);
    check("q_illegal", fmt_illegal, 1'b1);
    check("q_sgn", sgn, '0);
    check("q_exp", exp1, '0);
    check("q_sig", sig, '0);
    check("q_bias", bias, '0);
    check("q_nf", nf, '0);

    // Two-stage flow: 6 back-to-back requests, consumer stalls cycles 3-5
    sent = 0; recv = 0; occ = 0; stall_prev = 1'b0; sig_prev = '0;
    fmt2 = 2'd1;
    for (int c = 0; c < 40 && recv < 6; c++) begin
      @(negedge clk);
      out_ready2 = !(c >= 3 && c <= 5);
      in_valid2  = (sent < 6);
      x2         = {128'd0, 64'h3FF0000000000000 | 64'(sent)};
      #1;
      if (stall_prev) begin
        check("stall_valid", out_valid2, 1'b1);
        check("stall_sig", sig2, sig_prev);
      end
      check("flow_inready", in_ready2, !(occ == 2 && !out_ready2));
      if (out_valid2 && out_ready2) begin
        check("flow_order", sig2[52:0], ONE | 53'(recv));
        recv++;
        occ--;
      end
      if (in_valid2 && in_ready2) begin
        sent++;
        occ++;
      end
      stall_prev = out_valid2 && !out_ready2;
      sig_prev   = sig2;
    end
    check("flow_recv", recv, 6);
    @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    check("flow_drained", out_valid2, 1'b0);

    // Reset with two requests in flight
    out_ready2 = 1'b0;
    in_valid2  = 1'b1;
    x2         = {128'd0, 64'h3FF0000000000007};
    repeat (2) @(negedge clk);
    in_valid2 = 1'b0;
    #1;
    check("pre_rst_valid", out_valid2, 1'b1);
    check("pre_rst_inready", in_ready2, 1'b0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_valid2, 1'b0);
    check("mid_rst_inready", in_ready2, 1'b1);
    @(negedge clk);
    reset      = 1'b0;
    out_ready2 = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_valid", out_valid2, 1'b0);
    end
    check("post_rst_sig", sig2, '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
